// File: rtl/pll_seq_pkg.sv
// Shared types and constants for the PLL configuration sequencer.
// Holds the sequencer state encoding, the select/retry widths and the counter-width helper.
package pll_seq_pkg;

    localparam int SEL_W   = 6;
    localparam int RETRY_W = 2;

    typedef enum logic [2:0] {
        RESET,
        WAIT_LOCK,
        STABLE,
        RUN,
        FAIL
    } pll_state_t;

    // A counter that must reach max_val without wrapping.
    function automatic int cnt_width(input int max_val);
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Parameterized-width double-flop synchronizer for bringing asynchronous levels into clk.
// Each bit is synchronized independently; only use for signals without multi-bit coherency needs.
module sync_2ff #(
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    logic [DATA_W-1:0] meta_p0;
    logic [DATA_W-1:0] sync_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= '0;
            sync_p1 <= '0;
        end else begin
            // Stage 0 -> stage 1: meta_p0 may be metastable, sync_p1 is safe to use.
            meta_p0 <= d;
            sync_p1 <= meta_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/pll_cfg_sequencer.sv
// Bring-up, lock qualification and runtime reconfiguration controller for one device PLL.
// Define PLL_LOCK_LOSS_CNT_EN to add the saturating lock_loss_cnt output.
module pll_cfg_sequencer
    import pll_seq_pkg::*;
#(
    parameter logic [SEL_W-1:0] INIT_IDSEL    = 6'd0,
    parameter logic [SEL_W-1:0] INIT_FBDSEL   = 6'd0,
    parameter logic [SEL_W-1:0] INIT_ODSEL    = 6'd0,
    parameter int               RST_CYCLES    = 16,
    parameter int               LOCK_TIMEOUT  = 65535,
    parameter int               STABLE_CYCLES = 1024,
    parameter int               MAX_RETRY     = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [SEL_W-1:0]   cfg_idsel,
    input  logic [SEL_W-1:0]   cfg_fbdsel,
    input  logic [SEL_W-1:0]   cfg_odsel,
    input  logic               pll_lock,
    output logic               pll_reset,
    output logic [SEL_W-1:0]   pll_idsel,
    output logic [SEL_W-1:0]   pll_fbdsel,
    output logic [SEL_W-1:0]   pll_odsel,
    output logic               clk_ok,
    output logic               busy,
    output logic               err,
    output logic [RETRY_W-1:0] retry_cnt
`ifdef PLL_LOCK_LOSS_CNT_EN
    ,
    output logic [7:0]         lock_loss_cnt
`endif
);

    localparam int RST_W = cnt_width(RST_CYCLES);
    localparam int TO_W  = cnt_width(LOCK_TIMEOUT);
    localparam int STB_W = cnt_width(STABLE_CYCLES);

    localparam logic [RST_W-1:0] RST_LAST = RST_W'(RST_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(LOCK_TIMEOUT);
    localparam logic [STB_W-1:0] STB_LAST = STB_W'(STABLE_CYCLES - 1);

    pll_state_t         state, state_nxt;
    logic [RST_W-1:0]   rst_cnt, rst_cnt_nxt;
    logic [TO_W-1:0]    to_cnt, to_cnt_nxt, to_inc;
    logic [STB_W-1:0]   stb_cnt, stb_cnt_nxt;
    logic [RETRY_W-1:0] retry_nxt;
    logic               err_nxt;
    logic [SEL_W-1:0]   idsel_nxt, fbdsel_nxt, odsel_nxt;
    logic               lock_s;
    logic               handshake;
    logic               timeout;

    sync_2ff #(
        .DATA_W (1)
    ) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign handshake = cfg_valid && cfg_ready;

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = '0;
        to_cnt_nxt  = '0;
        stb_cnt_nxt = '0;
        to_inc      = to_cnt + 1'b1;
        retry_nxt   = retry_cnt;
        err_nxt     = err;
        idsel_nxt   = pll_idsel;
        fbdsel_nxt  = pll_fbdsel;
        odsel_nxt   = pll_odsel;
        timeout     = 1'b0;

        case (state)
            RESET: begin
                if (rst_cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    rst_cnt_nxt = rst_cnt + 1'b1;
                end
            end
            WAIT_LOCK: begin
                to_cnt_nxt = to_inc;
                if (to_inc >= TO_LIMIT) begin
                    timeout = 1'b1;
                end else if (lock_s) begin
                    state_nxt = STABLE;
                end
            end
            STABLE: begin
                // The timeout budget spans the whole attempt, so a lock glitch
                // restarts only the stability count.
                to_cnt_nxt = to_inc;
                if (lock_s && (stb_cnt == STB_LAST)) begin
                    state_nxt = RUN;
                    retry_nxt = '0;
                end else if (to_inc >= TO_LIMIT) begin
                    timeout = 1'b1;
                end else if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                end else begin
                    stb_cnt_nxt = stb_cnt + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s) begin
                    state_nxt = RESET;
                end
            end
            FAIL: begin
                state_nxt = FAIL;
            end
            default: begin
                state_nxt = RESET;
            end
        endcase

        if (timeout) begin
            to_cnt_nxt = '0;
            retry_nxt  = (retry_cnt == '1) ? retry_cnt : retry_cnt + 1'b1;
            if ((int'(retry_cnt) + 1) < MAX_RETRY) begin
                state_nxt = RESET;
            end else begin
                state_nxt = FAIL;
                err_nxt   = 1'b1;
            end
        end

        // A request beats a simultaneous lock loss so the new dividers are applied.
        if (handshake) begin
            state_nxt  = RESET;
            idsel_nxt  = cfg_idsel;
            fbdsel_nxt = cfg_fbdsel;
            odsel_nxt  = cfg_odsel;
            err_nxt    = 1'b0;
            retry_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= RESET;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            stb_cnt    <= '0;
            pll_reset  <= 1'b1;
            pll_idsel  <= INIT_IDSEL;
            pll_fbdsel <= INIT_FBDSEL;
            pll_odsel  <= INIT_ODSEL;
            clk_ok     <= 1'b0;
            cfg_ready  <= 1'b0;
            busy       <= 1'b1;
            err        <= 1'b0;
            retry_cnt  <= '0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            to_cnt     <= to_cnt_nxt;
            stb_cnt    <= stb_cnt_nxt;
            pll_reset  <= (state_nxt == RESET) || (state_nxt == FAIL);
            pll_idsel  <= idsel_nxt;
            pll_fbdsel <= fbdsel_nxt;
            pll_odsel  <= odsel_nxt;
            clk_ok     <= (state_nxt == RUN);
            cfg_ready  <= (state_nxt == RUN) || (state_nxt == FAIL);
            busy       <= (state_nxt == RESET) || (state_nxt == WAIT_LOCK) ||
                          (state_nxt == STABLE);
            err        <= err_nxt;
            retry_cnt  <= retry_nxt;
        end
    end

`ifdef PLL_LOCK_LOSS_CNT_EN
    logic lock_lost;

    assign lock_lost = (state == RUN) && !lock_s && !handshake;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_loss_cnt <= '0;
        end else if (lock_lost && (lock_loss_cnt != 8'hFF)) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_pll_cfg_sequencer.sv
// Directed bench for pll_cfg_sequencer: instance A (long timeout) and instance B (short timeout).
// Honors PLL_LOCK_LOSS_CNT_EN when the design is built with it.
module tb_pll_cfg_sequencer;

    logic       clk = 1'b0;
    logic       a_rst_n, b_rst_n;
    logic       cfg_valid;
    logic [5:0] cfg_idsel, cfg_fbdsel, cfg_odsel;
    logic       a_lock, b_lock;

    logic       a_cfg_ready, a_pll_reset, a_clk_ok, a_busy, a_err;
    logic [5:0] a_idsel, a_fbdsel, a_odsel;
    logic [1:0] a_retry;
    logic       b_cfg_ready, b_pll_reset, b_clk_ok, b_busy, b_err;
    logic [5:0] b_idsel, b_fbdsel, b_odsel;
    logic [1:0] b_retry;
`ifdef PLL_LOCK_LOSS_CNT_EN
    logic [7:0] a_llc, b_llc;
`endif

    int n_checks = 0;
    int n_errs   = 0;
    int n;

    always #5 clk = ~clk;

    pll_cfg_sequencer #(
        .RST_CYCLES(16), .LOCK_TIMEOUT(2000), .STABLE_CYCLES(1024), .MAX_RETRY(3)
    ) u_dut_a (
        .clk(clk), .rst_n(a_rst_n), .cfg_valid(cfg_valid), .cfg_ready(a_cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_lock(a_lock), .pll_reset(a_pll_reset), .pll_idsel(a_idsel),
        .pll_fbdsel(a_fbdsel), .pll_odsel(a_odsel), .clk_ok(a_clk_ok), .busy(a_busy),
        .err(a_err), .retry_cnt(a_retry)
`ifdef PLL_LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(a_llc)
`endif
    );

    pll_cfg_sequencer #(
        .RST_CYCLES(16), .LOCK_TIMEOUT(200), .STABLE_CYCLES(100), .MAX_RETRY(3)
    ) u_dut_b (
        .clk(clk), .rst_n(b_rst_n), .cfg_valid(cfg_valid), .cfg_ready(b_cfg_ready),
        .cfg_idsel(cfg_idsel), .cfg_fbdsel(cfg_fbdsel), .cfg_odsel(cfg_odsel),
        .pll_lock(b_lock), .pll_reset(b_pll_reset), .pll_idsel(b_idsel),
        .pll_fbdsel(b_fbdsel), .pll_odsel(b_odsel), .clk_ok(b_clk_ok), .busy(b_busy),
        .err(b_err), .retry_cnt(b_retry)
`ifdef PLL_LOCK_LOSS_CNT_EN
        , .lock_loss_cnt(b_llc)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Cycles until pll_reset falls (bounded).
    task automatic pulse_len(input bit sel_b, output int cnt);
        cnt = 0;
        while ((sel_b ? b_pll_reset : a_pll_reset) && cnt < 300) begin
            step();
            cnt++;
        end
    endtask

    // Cycles until clk_ok equals want (bounded).
    task automatic cycles_to_ok(input bit sel_b, input logic want, output int cnt);
        cnt = 0;
        while ((sel_b ? b_clk_ok : a_clk_ok) !== want && cnt < 4000) begin
            step();
            cnt++;
        end
    endtask

    // Cycles until B's retry_cnt leaves its current value or B qualifies (bounded).
    task automatic wait_b_retry(output int cnt);
        logic [1:0] from;
        from = b_retry;
        cnt  = 0;
        while (b_retry == from && !b_clk_ok && cnt < 500) begin
            step();
            cnt++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        a_rst_n = 1'b0; b_rst_n = 1'b0; a_lock = 1'b0; b_lock = 1'b0;
        cfg_valid = 1'b0; cfg_idsel = '0; cfg_fbdsel = '0; cfg_odsel = '0;
        repeat (3) step();

        // ---- A: reset state and power-on bring-up
        check("rst_pll_reset", a_pll_reset, 1);
        check("rst_busy", a_busy, 1);
        check("rst_clk_ok", a_clk_ok, 0);
        check("rst_cfg_ready", a_cfg_ready, 0);
        check("rst_err", a_err, 0);
        check("rst_retry", a_retry, 0);
        a_rst_n = 1'b1;
        pulse_len(1'b0, n);
        check("por_pulse_len", n, 16);
        repeat (50) step();
        a_lock = 1'b1;
        cycles_to_ok(1'b0, 1'b1, n);
        check("por_lock_to_clk_ok", n, 1027);
        check("por_retry", a_retry, 0);
        check("run_busy", a_busy, 0);
        check("run_cfg_ready", a_cfg_ready, 1);

        // ---- A: reconfiguration request in RUN
        cfg_valid = 1'b1; cfg_idsel = 6'd3; cfg_fbdsel = 6'd7; cfg_odsel = 6'd32;
        step();
        cfg_valid = 1'b0;
        a_lock = 1'b0;
        check("cfg_idsel", a_idsel, 3);
        check("cfg_fbdsel", a_fbdsel, 7);
        check("cfg_odsel", a_odsel, 32);
        check("cfg_clk_ok_drop", a_clk_ok, 0);
        check("cfg_ready_drop", a_cfg_ready, 0);
        pulse_len(1'b0, n);
        check("cfg_pulse_len", n, 16);
        repeat (50) step();
        a_lock = 1'b1;
        cycles_to_ok(1'b0, 1'b1, n);
        check("cfg_relock", n, 1027);
        check("cfg_err", a_err, 0);
        check("cfg_idsel_hold", a_idsel, 3);

        // ---- A: lock loss in RUN, then a glitch during STABLE on relock
        a_lock = 1'b0;
        cycles_to_ok(1'b0, 1'b0, n);
        check("loss_clk_ok_lat", n, 3);
        check("loss_pll_reset", a_pll_reset, 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("loss_cnt", a_llc, 1);
`endif
        pulse_len(1'b0, n);
        check("loss_pulse_len", n, 16);
        repeat (50) step();
        a_lock = 1'b1;
        repeat (503) step();
        a_lock = 1'b0;
        step();
        a_lock = 1'b1;
        cycles_to_ok(1'b0, 1'b1, n);
        check("glitch_restart", n, 1027);

        // ---- A: lock loss and request in the same cycle
        a_lock = 1'b0;
        repeat (2) step();
        cfg_valid = 1'b1; cfg_idsel = 6'd5; cfg_fbdsel = 6'd9; cfg_odsel = 6'd17;
        step();
        cfg_valid = 1'b0;
        check("simul_idsel", a_idsel, 5);
        check("simul_odsel", a_odsel, 17);
        check("simul_pll_reset", a_pll_reset, 1);
`ifdef PLL_LOCK_LOSS_CNT_EN
        check("simul_loss_cnt", a_llc, 1);
`endif

        // ---- A: asynchronous reset restores initial selects
        pulse_len(1'b0, n);
        repeat (5) step();
        #2 a_rst_n = 1'b0;
        #1;
        check("arst_idsel", a_idsel, 0);
        check("arst_pll_reset", a_pll_reset, 1);
        check("arst_busy", a_busy, 1);

        // ---- B: lock never rises -> three attempts then FAIL
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        pulse_len(1'b1, n);
        check("b_pulse_len", n, 16);
        wait_b_retry(n);
        check("b_timeout_cycles", n, 200);
        check("b_retry1", b_retry, 1);
        check("b_retry1_reset", b_pll_reset, 1);
        wait_b_retry(n);
        check("b_retry2", b_retry, 2);
        wait_b_retry(n);
        check("b_retry3", b_retry, 3);
        check("b_fail_err", b_err, 1);
        check("b_fail_ready", b_cfg_ready, 1);
        check("b_fail_busy", b_busy, 0);
        repeat (20) step();
        check("b_fail_reset_held", b_pll_reset, 1);
        check("b_fail_retry_held", b_retry, 3);

        // ---- B: request accepted in FAIL clears err/retry
        cfg_valid = 1'b1; cfg_idsel = 6'd1; cfg_fbdsel = 6'd2; cfg_odsel = 6'd4;
        step();
        cfg_valid = 1'b0;
        check("b_req_err", b_err, 0);
        check("b_req_retry", b_retry, 0);
        check("b_req_idsel", b_idsel, 1);
        check("b_req_ready", b_cfg_ready, 0);

        // ---- B: glitch in STABLE keeps original timeout budget
        pulse_len(1'b1, n);
        repeat (60) step();
        b_lock = 1'b1;
        repeat (63) step();
        b_lock = 1'b0;
        step();
        b_lock = 1'b1;
        wait_b_retry(n);
        b_lock = 1'b0;
        check("b_glitch_retry", b_retry, 1);
        check("b_glitch_clk_ok", b_clk_ok, 0);

        // ---- B: rst_n mid WAIT_LOCK
        pulse_len(1'b1, n);
        repeat (10) step();
        #2 b_rst_n = 1'b0;
        #1;
        check("b_arst_retry", b_retry, 0);
        check("b_arst_err", b_err, 0);
        check("b_arst_pll_reset", b_pll_reset, 1);
        check("b_arst_idsel", b_idsel, 0);
        check("b_arst_ready", b_cfg_ready, 0);
        @(posedge clk); #1;
        b_rst_n = 1'b1;
        pulse_len(1'b1, n);
        check("b_restart_pulse", n, 16);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
